multi_core_sel: RTL
===================

Name: multi_core_sel

Overview:
- Parametrised N-core selector for the SoC top.
- Replaces the fixed two-way combinational chip_sel mux with a registered selection, a safe switch-over sequencer and per-core reset gating.
- Muxes the selected core's data-bus master (m0), PC-fetch address (m1) and JTAG register read-back onto the shared rib/jtag paths.
- Produces registered over/succ indicators from the selected core's test-flag bits.

Parameters:
NCORES, 4, number of cores attached (2..16)
SELW, 2, width of core index (ceil(log2(NCORES)), min 1)
AW, 32, bus address width
DW, 32, bus data width
QUIET, 4, cycles all cores are held in reset during a switch (1..255)
DEFAULT_SEL, 0, core index active after reset

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-low reset
sel_i  in  SELW  requested core index
sel_req_i  in  1  one-cycle pulse: apply sel_i
core_ex_addr_i  in  NCORES*AW  per-core data-bus address, core k at [k*AW +: AW]
core_ex_data_i  in  NCORES*DW  per-core write data
core_ex_req_i  in  NCORES  per-core bus request
core_ex_we_i  in  NCORES  per-core write enable
core_pc_addr_i  in  NCORES*AW  per-core fetch address
core_jtag_rdata_i  in  NCORES*DW  per-core JTAG register read data
core_over_i  in  NCORES  per-core "run over" flag (reg x26 bit 0)
core_succ_i  in  NCORES  per-core "success" flag (reg x27 bit 0)
m0_ready_i  in  1  rib m0 ready/ack
m0_addr_o  out  AW  muxed data-bus address
m0_data_o  out  DW  muxed write data
m0_req_o  out  1  muxed request
m0_we_o  out  1  muxed write enable
m1_addr_o  out  AW  muxed fetch address
jtag_rdata_o  out  DW  muxed JTAG read data
core_rst_o  out  NCORES  per-core active-low reset
active_sel_o  out  SELW  currently active core
switching_o  out  1  high while not in RUN
over_o  out  1  active-low LED: 0 = selected core finished
succ_o  out  1  active-low LED: 0 = selected core passed

Behaviour:
- Reset (rst==0 at clk edge):
  - state=HOLD, counter=QUIET, active_sel=DEFAULT_SEL, pend_sel=DEFAULT_SEL.
  - core_rst_o=all 0, over_o=1, succ_o=1, switching_o=1.
- States:
  - RUN: core_rst_o bit active_sel =1, others 0; outputs mux core active_sel combinationally (zero latency). On sel_req_i with sel_i!=active_sel and sel_i<NCORES: capture pend_sel, go to DRAIN. A request equal to active_sel or out of range (>=NCORES) is ignored.
  - DRAIN: mux still points to active_sel. If m0_req_o==0, or m0_req_o==1 and m0_ready_i==1 this cycle, go to HOLD with counter=QUIET.
  - HOLD: core_rst_o=all 0; m0_req_o and m0_we_o forced 0. counter decrements each cycle; when counter==1 set active_sel=pend_sel and go to RUN. HOLD therefore lasts exactly QUIET cycles.
- A sel_req_i arriving in DRAIN or HOLD is dropped; no queueing.
- switching_o = (state!=RUN), registered with the state.
- over_o/succ_o registered one cycle late: RUN gives ~core_over_i[active_sel] / ~core_succ_i[active_sel]; other states give 1.
- m1_addr_o and jtag_rdata_o always follow active_sel, including in HOLD.
- Reset mid-switch: returns to HOLD with DEFAULT_SEL; pend_sel is discarded.

Optional Feature:
- Macro CORE_SEL_LOCK_EN.
- When defined:
  - Extra input lock_i (1 bit) and output locked_o (1 bit).
  - locked_o resets to 0 and is set sticky by lock_i==1 in RUN.
  - While locked_o==1, every sel_req_i is ignored until reset.
- When undefined: no lock ports; switching is always permitted.

Test Plan:
1. Reset with DEFAULT_SEL=0, QUIET=4, release rst -> core_rst_o=4'b0000 for 4 cycles, then 4'b0001; switching_o drops; active_sel_o=0.
2. In RUN, core 0 drives addr 0x1000_0004 req=1, core 2 drives 0x2000_0000 -> m0_addr_o=0x1000_0004 in the same cycle; core_over_i[0]=1 -> over_o=0 one cycle later.
3. sel_i=2 pulse while m0_req_o=1 and m0_ready_i=0 for 3 cycles -> DRAIN holds 3 cycles; on the ready cycle go to HOLD; core_rst_o=0 for 4 cycles; then core_rst_o=4'b0100, active_sel_o=2, m0_addr_o=0x2000_0000.
4. sel_req_i in HOLD with sel_i=1, and in RUN with sel_i=2 (already active) or with sel_i=3 when NCORES=3 -> all ignored; active_sel_o remains 2.
5. Assert rst during HOLD of a 0->3 switch -> after reset active_sel_o=0, not 3.
6. CORE_SEL_LOCK_EN defined: lock_i pulse, then sel_i=1 request -> locked_o=1, no DRAIN entered; after reset locked_o=0 and switching works again.

Source files
------------

// File: rtl/multi_core_sel.sv
// N-core selector: registered core selection with drain/quiet switch-over and per-core reset gating.
// Optional build macro CORE_SEL_LOCK_EN adds a sticky lock_i/locked_o that freezes the selection.
module multi_core_sel #(
    parameter int NCORES      = 4,
    parameter int SELW        = 2,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int QUIET       = 4,
    parameter int DEFAULT_SEL = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SELW-1:0]      sel_i,
    input  logic                 sel_req_i,
    input  logic [NCORES*AW-1:0] core_ex_addr_i,
    input  logic [NCORES*DW-1:0] core_ex_data_i,
    input  logic [NCORES-1:0]    core_ex_req_i,
    input  logic [NCORES-1:0]    core_ex_we_i,
    input  logic [NCORES*AW-1:0] core_pc_addr_i,
    input  logic [NCORES*DW-1:0] core_jtag_rdata_i,
    input  logic [NCORES-1:0]    core_over_i,
    input  logic [NCORES-1:0]    core_succ_i,
    input  logic                 m0_ready_i,
`ifdef CORE_SEL_LOCK_EN
    input  logic                 lock_i,
    output logic                 locked_o,
`endif
    output logic [AW-1:0]        m0_addr_o,
    output logic [DW-1:0]        m0_data_o,
    output logic                 m0_req_o,
    output logic                 m0_we_o,
    output logic [AW-1:0]        m1_addr_o,
    output logic [DW-1:0]        jtag_rdata_o,
    output logic [NCORES-1:0]    core_rst_o,
    output logic [SELW-1:0]      active_sel_o,
    output logic                 switching_o,
    output logic                 over_o,
    output logic                 succ_o
);

    typedef enum logic [1:0] {RUN, DRAIN, HOLD} state_t;

    localparam logic [7:0]      QUIET_C = 8'(QUIET);
    localparam logic [SELW-1:0] DEF_C   = SELW'(DEFAULT_SEL);

    state_t          state_reg, state_next;
    logic [7:0]      cnt_reg, cnt_next;
    logic [SELW-1:0] active_reg, active_next;
    logic [SELW-1:0] pend_reg, pend_next;
    logic            over_reg, succ_reg;
    logic            req_blocked;
    logic            sel_in_range;
    logic            act_req;

    logic [AW-1:0] ex_addr [NCORES];
    logic [DW-1:0] ex_data [NCORES];
    logic [AW-1:0] pc_addr [NCORES];
    logic [DW-1:0] jtag_rd [NCORES];

    genvar gi;
    generate
        for (gi = 0; gi < NCORES; gi++) begin : g_core
            assign ex_addr[gi]    = core_ex_addr_i[gi*AW +: AW];
            assign ex_data[gi]    = core_ex_data_i[gi*DW +: DW];
            assign pc_addr[gi]    = core_pc_addr_i[gi*AW +: AW];
            assign jtag_rd[gi]    = core_jtag_rdata_i[gi*DW +: DW];
            // Only the running core is let out of reset; every core is held during a switch.
            assign core_rst_o[gi] = (state_reg == RUN) && (active_reg == SELW'(gi));
        end
    endgenerate

`ifdef CORE_SEL_LOCK_EN
    logic locked_reg;
    assign req_blocked = locked_reg;
    assign locked_o    = locked_reg;
`else
    assign req_blocked = 1'b0;
`endif

    assign sel_in_range = (32'(sel_i) < 32'(NCORES));
    assign act_req      = core_ex_req_i[active_reg];

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        active_next = active_reg;
        pend_next   = pend_reg;
        case (state_reg)
            RUN: begin
                if (sel_req_i && !req_blocked && sel_in_range && (sel_i != active_reg)) begin
                    pend_next  = sel_i;
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Let an outstanding bus transaction complete before pulling resets.
                if (!act_req || m0_ready_i) begin
                    state_next = HOLD;
                    cnt_next   = QUIET_C;
                end
            end
            HOLD: begin
                if (cnt_reg == 8'd1) begin
                    active_next = pend_reg;
                    state_next  = RUN;
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            default: begin
                state_next = HOLD;
                cnt_next   = QUIET_C;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= HOLD;
            cnt_reg    <= QUIET_C;
            active_reg <= DEF_C;
            pend_reg   <= DEF_C;
            over_reg   <= 1'b1;
            succ_reg   <= 1'b1;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            active_reg <= active_next;
            pend_reg   <= pend_next;
            over_reg   <= (state_reg == RUN) ? ~core_over_i[active_reg] : 1'b1;
            succ_reg   <= (state_reg == RUN) ? ~core_succ_i[active_reg] : 1'b1;
        end
    end

`ifdef CORE_SEL_LOCK_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            locked_reg <= 1'b0;
        end else if ((state_reg == RUN) && lock_i) begin
            locked_reg <= 1'b1;
        end
    end
`endif

    assign m0_addr_o    = ex_addr[active_reg];
    assign m0_data_o    = ex_data[active_reg];
    assign m0_req_o     = (state_reg == HOLD) ? 1'b0 : act_req;
    assign m0_we_o      = (state_reg == HOLD) ? 1'b0 : core_ex_we_i[active_reg];
    assign m1_addr_o    = pc_addr[active_reg];
    assign jtag_rdata_o = jtag_rd[active_reg];
    assign active_sel_o = active_reg;
    assign switching_o  = (state_reg != RUN);
    assign over_o       = over_reg;
    assign succ_o       = succ_reg;

endmodule
